// File: rtl/step_tracker_pro_if.sv
// step_tracker_pro_if: step input, optional page button and display outputs of the step tracker
interface step_tracker_pro_if;
  logic       step_in;
`ifdef TRACKER_MANUAL_PAGE_EN
  logic       page_next;
`endif
  logic       si;
  logic [1:0] page;
  logic [4:0] bcd3, bcd2, bcd1, bcd0;
`ifdef TRACKER_MANUAL_PAGE_EN
  modport master (output step_in, page_next, input si, page, bcd3, bcd2, bcd1, bcd0);
  modport slave (input step_in, page_next, output si, page, bcd3, bcd2, bcd1, bcd0);
`else
  modport master (output step_in, input si, page, bcd3, bcd2, bcd1, bcd0);
  modport slave (input step_in, output si, page, bcd3, bcd2, bcd1, bcd0);
`endif
endinterface

// File: rtl/step_tracker_pro.sv
// step_tracker_pro: pedometer with distance/activity stats on four rotating BCD pages; TRACKER_MANUAL_PAGE_EN adds the page_next button
module step_tracker_pro #(
  parameter int TICK_DIV      = 100_000_000,
  parameter int CNT_W         = 24,
  parameter int HALF_MILE_LOG = 10,
  parameter int THRESH_LO     = 32,
  parameter int THRESH_HI     = 64,
  parameter int WINDOW_SEC    = 9,
  parameter int HIGH_MIN_SEC  = 60,
  parameter int PAGE_SEC      = 2
) (
  input logic               sys_clk,
  input logic               reset,
  step_tracker_pro_if.slave bus
);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(WINDOW_SEC + 1);
  localparam int RUN_W = $clog2(HIGH_MIN_SEC + 1);
  localparam int PT_W  = $clog2(4 * PAGE_SEC + 1);
  localparam logic [1:0] P_STEPS  = 2'd0;
  localparam logic [1:0] P_DIST   = 2'd1;
  localparam logic [1:0] P_ACTIVE = 2'd2;
  localparam logic [1:0] P_HIGH   = 2'd3;

  logic [2:0]       step_sync_q;
  logic             step_pulse_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [CNT_W-1:0] total_q, total_d;
  logic [7:0]       sec_q, sec_d;
  logic [IDX_W-1:0] idx_q, idx_d, act_q, act_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [13:0]      high_q, high_d, high_inc;
  logic [14:0]      high_sum;
  logic             hi;
  logic [1:0]       page_q, page_d, page_nxt;
  logic [PT_W-1:0]  pt_q, pt_d;
  logic             press, hold, adv;
  logic [19:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] miles_full;
  logic [6:0]       miles;
  logic [13:0]      num;
  logic [15:0]      dig;

  function automatic logic [15:0] dd(input logic [13:0] v);
    logic [15:0] b;
    b = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int k = 0; k < 4; k++)
        if (b[4*k +: 4] > 4'd4) b[4*k +: 4] = b[4*k +: 4] + 4'd3;
      b = {b[14:0], v[i]};
    end
    return b;
  endfunction

  // Synchronise the raw step input and emit one pulse per rising edge
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      step_sync_q  <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      step_sync_q  <= {step_sync_q[1:0], bus.step_in};
      step_pulse_q <= step_sync_q[1] & ~step_sync_q[2];
    end
  end

`ifdef TRACKER_MANUAL_PAGE_EN
  logic [2:0]      pn_sync_q;
  logic [PT_W-1:0] sus_q, sus_d;
  assign press = pn_sync_q[1] & ~pn_sync_q[2];
  assign hold  = sus_q != '0;
  assign sus_d = press ? PT_W'(4 * PAGE_SEC) : (tick && hold) ? sus_q - PT_W'(1) : sus_q;
  // Synchronise the page button and count down the auto-rotation suspension after a press
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pn_sync_q <= '0;
      sus_q     <= '0;
    end else begin
      pn_sync_q <= {pn_sync_q[1:0], bus.page_next};
      sus_q     <= sus_d;
    end
  end
`else
  assign press = 1'b0;
  assign hold  = 1'b0;
`endif

  assign tick = div_q == DIV_W'(TICK_DIV - 1);

  // Per-second statistics: saturating totals, activity window and sustained high-activity credit
  always_comb begin
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    total_d  = (step_pulse_q && !(&total_q)) ? total_q + CNT_W'(1) : total_q;
    sec_d    = tick ? {7'd0, step_pulse_q} : (step_pulse_q && !(&sec_q)) ? sec_q + 8'd1 : sec_q;
    idx_d    = (tick && idx_q != IDX_W'(WINDOW_SEC)) ? idx_q + IDX_W'(1) : idx_q;
    act_d    = (tick && idx_q != IDX_W'(WINDOW_SEC) && sec_q > 8'(THRESH_LO)) ? act_q + IDX_W'(1) : act_q;
    hi       = sec_q >= 8'(THRESH_HI);
    run_d    = !tick ? run_q : !hi ? '0 : (run_q == RUN_W'(HIGH_MIN_SEC)) ? run_q : run_q + RUN_W'(1);
    high_inc = !(tick && hi) ? 14'd0 : (run_q == RUN_W'(HIGH_MIN_SEC - 1)) ? 14'(HIGH_MIN_SEC) :
               (run_q == RUN_W'(HIGH_MIN_SEC)) ? 14'd1 : 14'd0;
    high_sum = {1'b0, high_q} + {1'b0, high_inc};
    high_d   = (high_sum > 15'd9999) ? 14'd9999 : high_sum[13:0];
  end

  // Page rotation: a button press or PAGE_SEC ticks of the page timer advance one page
  always_comb begin
    page_nxt = (page_q == P_STEPS) ? P_DIST : (page_q == P_DIST) ? P_ACTIVE : (page_q == P_ACTIVE) ? P_HIGH : P_STEPS;
    adv      = press || (tick && !hold && pt_q == PT_W'(PAGE_SEC - 1));
    page_d   = adv ? page_nxt : page_q;
    pt_d     = (adv || hold) ? '0 : tick ? pt_q + PT_W'(1) : pt_q;
  end

  // Select the value of the shown page and convert it to four display digits
  always_comb begin
    miles_full = total_q >> (HALF_MILE_LOG + 1);
    miles      = (miles_full > CNT_W'(99)) ? 7'd99 : miles_full[6:0];
    num        = (page_q == P_STEPS) ? ((total_q > CNT_W'(9999)) ? 14'd9999 : total_q[13:0]) :
                 (page_q == P_DIST) ? 14'(miles) : (page_q == P_ACTIVE) ? 14'(act_q) : high_q;
    dig        = dd(num);
    bcd_d      = (page_q == P_DIST) ?
                 {1'b0, dig[7:4], 1'b0, dig[3:0], 5'h1F, total_q[HALF_MILE_LOG] ? 5'd5 : 5'd0} :
                 {1'b0, dig[15:12], 1'b0, dig[11:8], 1'b0, dig[7:4], 1'b0, dig[3:0]};
  end

  // State registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_q   <= '0;
      total_q <= '0;
      sec_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      run_q   <= '0;
      high_q  <= '0;
      page_q  <= P_STEPS;
      pt_q    <= '0;
      bcd_q   <= '0;
    end else begin
      div_q   <= div_d;
      total_q <= total_d;
      sec_q   <= sec_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      run_q   <= run_d;
      high_q  <= high_d;
      page_q  <= page_d;
      pt_q    <= pt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.si   = total_q > CNT_W'(9999);
  assign bus.page = page_q;
  assign {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} = bcd_q;
endmodule

// File: tb/tb_step_tracker_pro.sv
// tb_step_tracker_pro: randomized step bursts scored against a per-second behavioural model of the tracker
module tb_step_tracker_pro;
  localparam int T = 100, CW = 16, HML = 4, LO = 8, HI = 16, W = 9, HM = 3, PG = 2;

  typedef struct {
    int          at;
    logic [1:0]  page;
    logic        si;
    logic [19:0] d;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   pulses[$];
  int   bcount[int];
  int   cyc = 0, acyc = 0, checks = 0, errors = 0;

  step_tracker_pro_if bus();

  step_tracker_pro #(
    .TICK_DIV(T), .CNT_W(CW), .HALF_MILE_LOG(HML), .THRESH_LO(LO), .THRESH_HI(HI),
    .WINDOW_SEC(W), .HIGH_MIN_SEC(HM), .PAGE_SEC(PG)
  ) dut (
    .sys_clk(sys_clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    acyc <= acyc + 1;
    cyc  <= rst ? 0 : cyc + 1;
  end

  function automatic int upto(input int c);
    int n = 0;
    foreach (pulses[i]) if (pulses[i] <= c) n++;
    return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
  endfunction

  function automatic int bk(input int s);
    if (!bcount.exists(s)) return 0;
    return (bcount[s] > 255) ? 255 : bcount[s];
  endfunction

  function automatic logic [19:0] dec4(input int v);
    return {1'b0, 4'(v / 1000 % 10), 1'b0, 4'(v / 100 % 10), 1'b0, 4'(v / 10 % 10), 1'b0, 4'(v % 10)};
  endfunction

  // Displayed state at cycle c reflects every event up to the previous clock edge
  function automatic exp_t expect_at(input int c);
    exp_t e;
    int nt = (c - 1) / T;
    int tot = upto(c - 1);
    int act = 0, run = 0, ht = 0, halves, miles;
    for (int j = 1; j <= nt; j++) begin
      int b = bk(j - 1);
      if (j <= W && b > LO) act++;
      if (b >= HI) begin
        run++;
        if (run == HM) ht += HM;
        else if (run > HM) ht++;
        if (ht > 9999) ht = 9999;
      end else run = 0;
    end
    halves = tot >> HML;
    miles  = (halves / 2 > 99) ? 99 : halves / 2;
    e.at   = acyc;
    e.page = 2'((c / T / PG) % 4);
    e.si   = upto(c) > 9999;
    case ((nt / PG) % 4)
      0:       e.d = dec4(tot > 9999 ? 9999 : tot);
      1:       e.d = {1'b0, 4'(miles / 10), 1'b0, 4'(miles % 10), 5'h1F, (halves % 2 == 1) ? 5'd5 : 5'd0};
      2:       e.d = dec4(act);
      default: e.d = dec4(ht);
    endcase
    return e;
  endfunction

  task automatic cmp(input string nm, input int at, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, at, got, want);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic step();
    int p = cyc + 4;
    pulses.push_back(p);
    if (!bcount.exists(p / T)) bcount[p / T] = 0;
    bcount[p / T]++;
    bus.step_in = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 bus.step_in = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (!rst && cyc >= 5 && cyc % T == 5) sb.push_back(expect_at(cyc));
  end

  always @(negedge sys_clk) begin
    while (sb.size() > 0 && sb[0].at <= acyc) begin
      exp_t e;
      e = sb.pop_front();
      cmp("page", e.at, 32'(bus.page), 32'(e.page));
      cmp("si", e.at, 32'(bus.si), 32'(e.si));
      cmp("digits", e.at, 32'({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}), 32'(e.d));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int sn[16] = '{9, 8, 9, 8, 16, 16, 16, 15, 16, 16, 8, 16, 16, 16, 16, 16};
    int ss[16] = '{10, 10, 64, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_t r;
    bus.step_in = 1'b0;
`ifdef TRACKER_MANUAL_PAGE_EN
    bus.page_next = 1'b0;
`endif
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    wait_until(10);
    repeat (57) step();
    wait_until(455);
    r.at = acyc + 1;
    r.page = 2'd0;
    r.si = 1'b0;
    r.d = '0;
    sb.push_back(r);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    pulses.delete();
    bcount.delete();
    rst = 1'b0;
    for (int s = 0; s < 16; s++) begin
      wait_until(T * s + ss[s]);
      repeat (sn[s]) step();
    end
    for (int s = 16; s < 36; s++) begin
      int n = $urandom_range(0, 24);
      int st = $urandom_range(0, 100 - 4 * n);
      if ($urandom_range(0, 3) == 0) st = 100 - 4 * n;
      wait_until(T * s + st);
      repeat (n) step();
    end
    repeat (10001) step();
    wait_until(cyc + 250);
    repeat (3) @(posedge sys_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
